// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b - bin.
// One full-subtractor cell plus a borrow flip-flop processes one bit per
// clock, LSB first. A start/busy/done handshake frames each operation and
// the diff/bout outputs are updated only when an operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter must index WIDTH bit positions; keep at least one bit for WIDTH=1.
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic br);
        logic d_v;
        logic b_v;
        d_v = x ^ y ^ br;
        b_v = (~x & y) | (~(x ^ y) & br);
        return {b_v, d_v};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [1:0]       w_cell;
    logic             w_d;
    logic             w_borrow_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_cell        = fs_cell(r_a_sr[0], r_b_sr[0], r_borrow);
    assign w_d           = w_cell[0];
    assign w_borrow_next = w_cell[1];
    assign w_last        = (r_cnt == LAST_BIT);

    // Result shift register with the current difference bit entering at the MSB.
    always_comb begin
        w_res_next            = r_res_sr >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    // Control FSM and datapath: load on start, shift one bit per RUN cycle, publish on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_res_sr <= '0;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here: operands are fixed for the whole run.
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_borrow <= w_borrow_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_diff  <= w_res_next;
                        r_bout  <= w_borrow_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance exercised with
// directed and random operations, and a 1-bit instance swept exhaustively.
// Expected results come from plain integer arithmetic.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] last_diff;
    logic       last_bout;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: unsigned a - b - bin with plain integer arithmetic.
    function automatic logic [8:0] ref_sub(input int width, input int av, input int bv, input int biv);
        int r;
        int m;
        logic [8:0] res;
        r   = av - bv - biv;
        m   = (1 << width) - 1;
        res = '0;
        res[7:0] = 8'((r + (1 << width) * 2) & m);
        res[8]   = (av < bv + biv);
        return res;
    endfunction

    // One 8-bit operation; starts at a negedge, returns at the negedge where done is high.
    task automatic op8(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v, input bit noise);
        logic [8:0] exp_v;
        logic [7:0] prev_diff;
        logic       prev_bout;
        int         busy_cnt;
        bit         hold_ok;
        bit         overlap_ok;
        bit         seen;
        exp_v      = ref_sub(8, int'(a_v), int'(b_v), int'(bin_v));
        start8     = 1'b1;
        a8         = a_v;
        b8         = b_v;
        bin8       = bin_v;
        @(negedge clk);
        start8     = 1'b0;
        prev_diff  = diff8;
        prev_bout  = bout8;
        busy_cnt   = 0;
        hold_ok    = 1'b1;
        overlap_ok = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done8 && busy8) overlap_ok = 1'b0;
            if (done8) begin
                seen = 1'b1;
                break;
            end
            if (busy8) busy_cnt++;
            if (diff8 !== prev_diff || bout8 !== prev_bout) hold_ok = 1'b0;
            if (noise && i >= 1 && i <= 4) begin
                start8 = 1'b1;
                a8     = 8'h00;
                b8     = 8'hFF;
                bin8   = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("busy_cycles", 32'(busy_cnt), 32'd8);
        check_val("busy_at_done", 32'(busy8), 32'd0);
        check_val("done_busy_overlap", 32'(overlap_ok), 32'd1);
        check_val("hold_during_run", 32'(hold_ok), 32'd1);
        check_val("diff", 32'(diff8), 32'(exp_v[7:0]));
        check_val("bout", 32'(bout8), 32'(exp_v[8]));
        last_diff = exp_v[7:0];
        last_bout = exp_v[8];
    endtask

    // Cycle after a completion with no new start: done drops, result held.
    task automatic post_done();
        @(negedge clk);
        check_val("done_fall", 32'(done8), 32'd0);
        check_val("idle_busy", 32'(busy8), 32'd0);
        check_val("diff_held", 32'(diff8), 32'(last_diff));
        check_val("bout_held", 32'(bout8), 32'(last_bout));
    endtask

    initial begin
        int done_cnt;
        logic [8:0] e1;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  bin1 = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy8), 32'd0);
        check_val("rst_done", 32'(done8), 32'd0);
        check_val("rst_diff", 32'(diff8), 32'd0);
        check_val("rst_bout", 32'(bout8), 32'd0);
        check_val("rst_w1_diff", 32'(diff1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        op8(8'h5A, 8'h21, 1'b0, 1'b0); post_done();
        op8(8'h00, 8'h01, 1'b0, 1'b0); post_done();
        op8(8'h10, 8'h10, 1'b1, 1'b0); post_done();
        op8(8'hFF, 8'h00, 1'b0, 1'b0); post_done();

        // Starts during RUN are ignored; exactly one done pulse.
        op8(8'h80, 8'h01, 1'b0, 1'b1); post_done();
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        check_val("no_extra_done", 32'(done_cnt), 32'd0);

        // Back-to-back: second operation launched at the DONE edge.
        op8(8'h44, 8'h11, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 1'b0, 1'b0); post_done();

        // Reset in the middle of RUN aborts the operation.
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 32'(busy8), 32'd0);
        check_val("midrst_done", 32'(done8), 32'd0);
        check_val("midrst_diff", 32'(diff8), 32'd0);
        check_val("midrst_bout", 32'(bout8), 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8 || busy8) done_cnt++;
        end
        check_val("midrst_no_done", 32'(done_cnt), 32'd0);

        // Random operations, sometimes chained back-to-back.
        for (int k = 0; k < 24; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) post_done();
        end
        post_done();

        // WIDTH=1: full-subtractor truth table.
        for (int c = 0; c < 8; c++) begin
            e1     = ref_sub(1, (c >> 2) & 1, (c >> 1) & 1, c & 1);
            start1 = 1'b1;
            a1     = 1'((c >> 2) & 1);
            b1     = 1'((c >> 1) & 1);
            bin1   = 1'(c & 1);
            @(negedge clk);
            start1 = 1'b0;
            check_val("w1_busy", 32'(busy1), 32'd1);
            check_val("w1_done_early", 32'(done1), 32'd0);
            @(negedge clk);
            check_val("w1_done", 32'(done1), 32'd1);
            check_val("w1_busy_off", 32'(busy1), 32'd0);
            check_val("w1_diff", 32'(diff1), 32'(e1[0]));
            check_val("w1_bout", 32'(bout1), 32'(e1[8]));
        end
        @(negedge clk);
        check_val("w1_done_fall", 32'(done1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
